// File: rtl/x_uart_pkg.sv
// x_uart_pkg: shared UART types (parity mode, receiver states) and baud timing helper
package x_uart_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} par_t;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

    // Compare value for a full bit period: T - 1 clocks after a timer clear
    function automatic int calc_timer_top(input int clk_hz, input int baud);
        return clk_hz / baud - 1;
    endfunction

endpackage

// File: rtl/x_uart_rx_cfg_if.sv
// x_uart_rx_cfg_if: serial line, consumer acknowledge and received-character status bundle
interface x_uart_rx_cfg_if #(parameter int p_data_bits = 8);

    logic                   i_rx;
    logic                   i_ack;
    logic                   o_valid;
    logic [p_data_bits-1:0] o_data;
    logic                   o_parity_err;
    logic                   o_frame_err;
    logic                   o_break;
    logic                   o_overrun;

    modport master (
        output i_rx, i_ack,
        input  o_valid, o_data, o_parity_err, o_frame_err, o_break, o_overrun
    );

    modport slave (
        input  i_rx, i_ack,
        output o_valid, o_data, o_parity_err, o_frame_err, o_break, o_overrun
    );

endinterface

// File: rtl/x_uart_baud_timer.sv
// x_uart_baud_timer: clearable up-counter with match against a run-time top value
module x_uart_baud_timer #(
    parameter int p_width = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [p_width-1:0] top,
    output logic               match
);

    logic [p_width-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 1'b1;

    assign match = (cnt == top);

endmodule

// File: rtl/x_uart_rx_cfg.sv
// x_uart_rx_cfg: configurable UART receiver (5..9 data bits, optional parity, 1/2 stop bits)
// with false-start rejection, parity/framing/break flags and sticky overrun.
module x_uart_rx_cfg
    import x_uart_pkg::*;
#(
    parameter int   p_clk_hz    = 1000000,
    parameter int   p_baud      = 9600,
    parameter int   p_data_bits = 8,
    parameter par_t p_parity    = PAR_NONE,
    parameter int   p_stop_bits = 1
) (
    input logic            i_clk,
    input logic            i_nrst,
    x_uart_rx_cfg_if.slave bus
);

    localparam int T  = calc_timer_top(p_clk_hz, p_baud) + 1;
    localparam int H  = T / 2;
    localparam int TW = $clog2(T);

    if (T < 4) begin : g_bad_baud
        $error("x_uart_rx_cfg: bit period must be at least 4 clocks");
    end
    if (p_data_bits < 5 || p_data_bits > 9) begin : g_bad_bits
        $error("x_uart_rx_cfg: p_data_bits must be 5..9");
    end
    if (p_stop_bits < 1 || p_stop_bits > 2) begin : g_bad_stop
        $error("x_uart_rx_cfg: p_stop_bits must be 1 or 2");
    end

    rx_state_t              state, nxt;
    logic [2:0]             sync;
    logic [3:0]             bit_cnt;
    logic [p_data_bits-1:0] sh;
    logic [TW-1:0]          top;
    logic rx_s, fall, run, match, smp, clr, done, last_data, last_stop;
    logic par, fe, fe_n, pend;

    // sync[1] is the synchronised line, sync[2] its one-cycle history
    assign rx_s      = sync[1];
    assign fall      = !sync[1] && sync[2];
    assign run       = (state != IDLE);
    assign top       = (state == START) ? TW'(H - 1) : TW'(T - 1);
    assign smp       = run && match;
    assign clr       = !run || smp;
    assign last_data = (bit_cnt == 4'(p_data_bits - 1));
    assign last_stop = (bit_cnt == 4'(p_stop_bits - 1));
    assign done      = smp && (state == STOP) && last_stop;
    assign fe_n      = fe | ~rx_s;

    x_uart_baud_timer #(.p_width(TW)) u_timer (
        .clk   (i_clk),
        .rst_n (i_nrst),
        .clr   (clr),
        .en    (run),
        .top   (top),
        .match (match)
    );

    always_ff @(posedge i_clk or negedge i_nrst)
        if (!i_nrst) state <= IDLE;
        else         state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = fall ? START : IDLE;
            START:   nxt = match ? (rx_s ? IDLE : DATA) : START;
            DATA:    nxt = (match && last_data) ? ((p_parity != PAR_NONE) ? PARITY : STOP) : DATA;
            PARITY:  nxt = match ? STOP : PARITY;
            STOP:    nxt = (match && last_stop) ? IDLE : STOP;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst)
        if (!i_nrst) begin
            sync             <= 3'b111;
            bit_cnt          <= '0;
            sh               <= '0;
            par              <= 1'b0;
            fe               <= 1'b0;
            pend             <= 1'b0;
            bus.o_valid      <= 1'b0;
            bus.o_data       <= '0;
            bus.o_parity_err <= 1'b0;
            bus.o_frame_err  <= 1'b0;
            bus.o_break      <= 1'b0;
            bus.o_overrun    <= 1'b0;
        end else begin
            sync <= {sync[1:0], bus.i_rx};
            if (!run) begin
                bit_cnt <= '0;
                fe      <= 1'b0;
            end
            if (smp && state == DATA) begin
                sh      <= {rx_s, sh[p_data_bits-1:1]};
                bit_cnt <= last_data ? '0 : bit_cnt + 4'd1;
            end
            if (smp && state == PARITY) par <= rx_s;
            if (smp && state == STOP) begin
                fe      <= fe_n;
                bit_cnt <= bit_cnt + 4'd1;
            end
            bus.o_valid <= done;
            if (done) begin
                bus.o_data       <= sh;
                bus.o_parity_err <= (p_parity == PAR_NONE) ? 1'b0 : ((^sh) ^ par ^ (p_parity == PAR_ODD));
                bus.o_frame_err  <= fe_n;
                bus.o_break      <= fe_n && ~|sh && !(p_parity != PAR_NONE && par);
            end
            // An ack in the o_valid cycle acknowledges the character just delivered
            pend          <= bus.o_valid ? ~bus.i_ack : pend & ~bus.i_ack;
            bus.o_overrun <= (done & pend & ~bus.i_ack) | (bus.o_overrun & ~bus.i_ack);
        end

endmodule

// File: tb/tb_x_uart_rx_cfg.sv
// tb_x_uart_rx_cfg: scoreboard bench driving 8N1, 8E1 and 7O2 receivers at T=10, H=5
module tb_x_uart_rx_cfg;
    import x_uart_pkg::*;

    localparam int CLK  = 1000000;
    localparam int BAUD = 100000;
    localparam int T    = CLK / BAUD;
    localparam int H    = T / 2;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    logic [2:0] rx  = 3'b111;
    logic [2:0] ack = 3'b000;
    int cyc = 0;
    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         inst;
        logic [8:0] d;
        logic       pe, fe, brk, ovr;
        int         t0, lat;
    } exp_t;

    exp_t q[$];
    logic [2:0] pend_m = '0;
    logic [2:0] ovr_m  = '0;
    int nb_c[3] = '{8, 8, 7};
    int pm_c[3] = '{0, 2, 1};
    int ns_c[3] = '{1, 1, 2};

    x_uart_rx_cfg_if #(.p_data_bits(8)) b0 ();
    x_uart_rx_cfg_if #(.p_data_bits(8)) b1 ();
    x_uart_rx_cfg_if #(.p_data_bits(7)) b2 ();

    assign b0.i_rx = rx[0];
    assign b1.i_rx = rx[1];
    assign b2.i_rx = rx[2];
    assign b0.i_ack = ack[0];
    assign b1.i_ack = ack[1];
    assign b2.i_ack = ack[2];

    x_uart_rx_cfg #(.p_clk_hz(CLK), .p_baud(BAUD), .p_data_bits(8), .p_parity(PAR_NONE), .p_stop_bits(1))
        d0 (.i_clk(clk), .i_nrst(nrst), .bus(b0));
    x_uart_rx_cfg #(.p_clk_hz(CLK), .p_baud(BAUD), .p_data_bits(8), .p_parity(PAR_EVEN), .p_stop_bits(1))
        d1 (.i_clk(clk), .i_nrst(nrst), .bus(b1));
    x_uart_rx_cfg #(.p_clk_hz(CLK), .p_baud(BAUD), .p_data_bits(7), .p_parity(PAR_ODD), .p_stop_bits(2))
        d2 (.i_clk(clk), .i_nrst(nrst), .bus(b2));

    logic [2:0] vld;
    logic [8:0] dat [3];
    logic [3:0] flg [3];

    assign vld    = {b2.o_valid, b1.o_valid, b0.o_valid};
    assign dat[0] = {1'b0, b0.o_data};
    assign dat[1] = {1'b0, b1.o_data};
    assign dat[2] = {2'b0, b2.o_data};
    assign flg[0] = {b0.o_parity_err, b0.o_frame_err, b0.o_break, b0.o_overrun};
    assign flg[1] = {b1.o_parity_err, b1.o_frame_err, b1.o_break, b1.o_overrun};
    assign flg[2] = {b2.o_parity_err, b2.o_frame_err, b2.o_break, b2.o_overrun};

    // Scoreboard consumer: every o_valid must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) if (vld[i]) begin
            checks++;
            if (q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_valid inst=%0d got data=%h flags=%b, required no valid", i, dat[i], flg[i]);
            end else begin
                e = q.pop_front();
                if (i != e.inst || dat[i] !== e.d || flg[i] !== {e.pe, e.fe, e.brk, e.ovr}) begin
                    errs++;
                    $display("FAIL char inst=%0d data=%h pe/fe/brk/ovr=%b, required inst=%0d data=%h pe/fe/brk/ovr=%b",
                             i, dat[i], flg[i], e.inst, e.d, {e.pe, e.fe, e.brk, e.ovr});
                end
                checks++;
                if (cyc - e.t0 != e.lat) begin
                    errs++;
                    $display("FAIL latency inst=%0d got %0d cycles, required %0d", i, cyc - e.t0, e.lat);
                end
            end
        end
    end

    // Called at posedge+1; pushes the expected character, then drives the frame bit by bit
    task automatic send_frame(input int inst, input logic [8:0] d, input logic pb,
                              input logic [1:0] st, input logic tail);
        logic [15:0] bits;
        int n, nb, pm, ns;
        logic xd;
        exp_t e;
        nb = nb_c[inst];
        pm = pm_c[inst];
        ns = ns_c[inst];
        bits = '0;
        n = 1;
        for (int i = 0; i < nb; i++) begin bits[n] = d[i]; n++; end
        if (pm != 0) begin bits[n] = pb; n++; end
        for (int i = 0; i < ns; i++) begin bits[n] = st[i]; n++; end
        xd = ^d;
        e.inst = inst;
        e.d    = d;
        e.pe   = (pm == 0) ? 1'b0 : (pm == 2) ? (xd ^ pb) : ~(xd ^ pb);
        e.fe   = (ns == 1) ? ~st[0] : ~(st[0] & st[1]);
        e.brk  = e.fe && (d == 9'h0) && (pm == 0 || pb == 1'b0);
        e.ovr  = ovr_m[inst] | pend_m[inst];
        ovr_m[inst]  = e.ovr;
        pend_m[inst] = 1'b1;
        e.lat  = 3 + H + T * (nb + ((pm != 0) ? 1 : 0) + ns);
        e.t0   = cyc;
        q.push_back(e);
        for (int i = 0; i < n; i++) begin
            rx[inst] = bits[i];
            repeat (T) @(posedge clk);
            #1;
        end
        rx[inst] = tail;
    endtask

    task automatic idle(input int bits_n);
        repeat (bits_n * T) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack(input int inst);
        ack[inst] = 1'b1;
        @(posedge clk);
        #1;
        ack[inst] = 1'b0;
        pend_m[inst] = 1'b0;
        ovr_m[inst]  = 1'b0;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL %s_drained got %0d pending characters, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({vld[i], dat[i], flg[i]} !== 14'h0) begin
                errs++;
                $display("FAIL reset_outputs inst=%0d got valid=%b data=%h flags=%b, required all 0", i, vld[i], dat[i], flg[i]);
            end
        end
        nrst = 1'b1;
        idle(2);
    endtask

    task automatic test_8n1();
        send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b1);
        idle(2);
        check_drained("8n1");
    endtask

    task automatic test_parity();
        send_frame(1, 9'h007, 1'b0, 2'b11, 1'b1);
        idle(1);
        send_frame(1, 9'h007, 1'b1, 2'b11, 1'b1);
        idle(2);
        check_drained("parity");
    endtask

    task automatic test_stop_break();
        send_frame(2, 9'h041, 1'b1, 2'b01, 1'b1);
        idle(2);
        send_frame(2, 9'h000, 1'b0, 2'b00, 1'b0);
        idle(19);
        rx[2] = 1'b1;
        idle(3);
        check_drained("stop_break");
    endtask

    task automatic test_glitch();
        logic seen;
        seen = 1'b0;
        rx[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (d0.state == START) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin
            errs++;
            $display("FAIL glitch_start got start_seen=%b, required 1", seen);
        end
        checks++;
        if (d0.state !== IDLE) begin
            errs++;
            $display("FAIL glitch_idle got state=%0d, required IDLE", d0.state);
        end
        @(posedge clk);
        #1;
        idle(1);
        send_frame(0, 9'h03C, 1'b0, 2'b11, 1'b1);
        idle(2);
        check_drained("glitch");
    endtask

    task automatic test_back_to_back();
        pulse_ack(0);
        checks++;
        if (b0.o_overrun !== 1'b0) begin
            errs++;
            $display("FAIL ack_clear0 got overrun=%b, required 0", b0.o_overrun);
        end
        send_frame(0, 9'h011, 1'b0, 2'b11, 1'b1);
        send_frame(0, 9'h022, 1'b0, 2'b11, 1'b1);
        idle(1);
        checks++;
        if (b0.o_overrun !== 1'b1) begin
            errs++;
            $display("FAIL overrun_sticky got overrun=%b, required 1", b0.o_overrun);
        end
        pulse_ack(0);
        checks++;
        if (b0.o_overrun !== 1'b0) begin
            errs++;
            $display("FAIL ack_clear got overrun=%b, required 0", b0.o_overrun);
        end
        fork
            send_frame(0, 9'h033, 1'b0, 2'b11, 1'b1);
            begin
                int k;
                k = 0;
                while (!vld[0] && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                checks++;
                if (!vld[0]) begin
                    errs++;
                    $display("FAIL coincident_ack_wait got no valid in %0d cycles, required valid", k);
                end else begin
                    ack[0] = 1'b1;
                    @(posedge clk);
                    #1;
                    ack[0] = 1'b0;
                end
            end
        join
        pend_m[0] = 1'b0;
        ovr_m[0]  = 1'b0;
        idle(1);
        checks++;
        if (b0.o_overrun !== 1'b0) begin
            errs++;
            $display("FAIL coincident_ack got overrun=%b, required 0", b0.o_overrun);
        end
        send_frame(0, 9'h044, 1'b0, 2'b11, 1'b1);
        idle(2);
        check_drained("back_to_back");
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic [4:0] pre;
        d = 8'h5A;
        pre = {d[3:0], 1'b0};
        for (int i = 0; i < 4; i++) begin
            rx[0] = pre[i];
            repeat (T) @(posedge clk);
            #1;
        end
        rx[0] = pre[4];
        repeat (5) @(posedge clk);
        #2;
        nrst = 1'b0;
        pend_m = '0;
        ovr_m  = '0;
        #1;
        checks++;
        if ({vld[0], dat[0], flg[0]} !== 14'h0) begin
            errs++;
            $display("FAIL reset_mid_outputs got valid=%b data=%h flags=%b, required all 0", vld[0], dat[0], flg[0]);
        end
        checks++;
        if (d0.state !== IDLE) begin
            errs++;
            $display("FAIL reset_mid_state got state=%0d, required IDLE", d0.state);
        end
        rx[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1;
        idle(2);
        send_frame(0, 9'h05A, 1'b0, 2'b11, 1'b1);
        idle(2);
        check_drained("reset_mid");
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_stop_break();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
